crc16_t: RTL and testbench
==========================

# crc16_t

Transmit-side DATA-phase CRC16 generator between the link layer (`tx_lt_*`) and the PHY (`tx_*`). It forwards a packet byte-by-byte through one registered output stage. For DATA packets it computes the USB CRC16 over the payload and appends the two CRC bytes after the last payload byte, moving EOP onto the final CRC byte. It is the transmit counterpart of `crc16_r` and is enabled by the link controller through `tx_data_on`.

## Interface
- No parameters. The CRC is fixed to USB CRC16.
- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `tx_data_on`  in  1  block enable from link controller
- `tx_sop_en`  out  1  1-cycle pulse: PID byte accepted from link layer
- `tx_lt_eop_en`  out  1  1-cycle pulse: final byte of the packet (with EOP) accepted by PHY
- `tx_lt_sop`  in  1  first byte (PID) marker from link layer
- `tx_lt_eop`  in  1  last byte marker from link layer
- `tx_lt_valid`  in  1  link-layer byte valid
- `tx_lt_ready`  out  1  block can accept a byte
- `tx_lt_data`  in  8  link-layer byte
- `tx_sop`  out  1  first byte marker to PHY
- `tx_eop`  out  1  last byte marker to PHY
- `tx_valid`  out  1  output byte valid
- `tx_ready`  in  1  PHY accepts the byte
- `tx_data`  out  8  byte to PHY

## Operation
- FSM states: IDLE, DATA, PASS, CRC_LO, CRC_HI.
- Input accept: `acc = tx_lt_valid & tx_lt_ready`.
- Output accept: `oacc = tx_valid & tx_ready`.
- `tx_lt_ready = tx_data_on & (state in IDLE/DATA/PASS) & (~tx_valid | tx_ready)`.
- IDLE:
  - `acc` with `tx_lt_sop`=1 loads the output register (sop=1) and pulses `tx_sop_en`.
  - If `tx_lt_data[1:0]==2'b11` (DATA PID): crc<=16'hFFFF and go to DATA. The PID byte is excluded from the CRC.
  - Otherwise go to PASS. Tokens and handshakes are forwarded unchanged and no CRC is appended.
  - If `tx_lt_eop`=1 on the PID byte:
    - PASS case: the byte goes out with sop=1 and eop=1, and the FSM returns to IDLE.
    - DATA case: zero-length payload, go to CRC_LO.
  - `acc` without sop in IDLE: the byte is dropped and no state change occurs.
- DATA: each `acc` forwards the byte (sop=0, eop=0) and updates crc.
  - Update: reflected CRC-16 (poly 0x8005, reflected 0xA001), LSB of byte first, all 8 bits in one cycle.
  - `acc` with eop: the byte is forwarded with eop=0 and the FSM goes to CRC_LO.
- PASS: bytes are forwarded unchanged, including eop. `acc` with eop returns the FSM to IDLE.
- `tx_lt_sop` is ignored outside IDLE; such a byte is treated as an ordinary byte.
- CRC_LO: when the output register frees (`~tx_valid | tx_ready`), load `~crc[7:0]` with sop=0, eop=0, then go to CRC_HI.
- CRC_HI: when the output register frees, load `~crc[15:8]` with eop=1, then go to IDLE.
- `tx_lt_eop_en` pulses in the cycle where `oacc` occurs on a byte with `tx_eop`=1.
- `tx_data_on` deasserted in any non-IDLE state aborts the packet:
  - Next cycle: FSM to IDLE, `tx_valid`=0.
  - No EOP is emitted and `tx_lt_eop_en` does not pulse.
- `tx_data_on` low in IDLE: `tx_lt_ready`=0.

## Timing
- Reset values (registered outputs): `tx_valid`, `tx_sop`, `tx_eop`=0; `tx_data`=8'h00; crc=16'hFFFF; state IDLE.
- Reset values (pulses): `tx_sop_en`, `tx_lt_eop_en`=0.
- `tx_lt_ready` is combinational and stays 0 while `rst` is high.
- `rst` asserted mid-packet takes effect on the next edge; the packet is discarded with no EOP.
- Latency: a byte accepted in cycle N appears on `tx_*` in cycle N+1.
- Throughput: one byte per cycle when `tx_ready`=1.
- CRC bytes follow the last payload byte with no gap when `tx_ready` stays high.
- A DATA packet with P payload bytes occupies P+3 output beats.
- Output hold: while `tx_valid` & ~`tx_ready`, `tx_data`/`tx_sop`/`tx_eop` are stable and `tx_lt_ready`=0.
- `tx_lt_ready`=0 throughout CRC_LO and CRC_HI.
- `tx_sop_en` is combinational from `acc` in IDLE. `tx_lt_eop_en` is combinational from `oacc & tx_eop`.

## Test plan
- DATA0 PID 0xC3 + ASCII "123456789" (0x31..0x39, eop on 0x39), `tx_ready`=1 -> out: C3(sop), 31..39, C8, B4(eop). `tx_lt_eop_en` pulses once, with B4.
- Zero-length DATA1: 0x4B with sop=eop=1 -> out: 4B(sop), 00, 00(eop). No `tx_lt_ready` during CRC beats.
- ACK 0xD2 with sop=eop=1 -> out: single D2 with sop=eop=1. No CRC bytes; `tx_sop_en` and `tx_lt_eop_en` each pulse once.
- Backpressure on the "123456789" packet, `tx_ready` toggled 1,0,0,1 randomly -> same byte sequence as the first scenario. Outputs stable while stalled, no bytes lost or duplicated.
- `tx_data_on` dropped after 4 payload bytes -> `tx_valid`=0 next cycle, no eop. A following 0x4B zero-length packet then outputs 4B, 00, 00, which shows the CRC was reinitialised.
- `rst` asserted during CRC_LO -> all outputs 0 next cycle. Non-sop bytes offered afterward in IDLE are dropped.

Source files
------------

// File: rtl/crc16_t.sv
// Forwards link-layer bytes to the PHY through one output register (1-cycle latency), appending USB CRC16 to DATA packets.
// Backpressure: accepts only when the output register is empty or draining; input is held off while CRC bytes go out.
module crc16_t (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_data_on,
    output logic       o_tx_sop_en,
    output logic       o_tx_lt_eop_en,
    input  logic       i_tx_lt_sop,
    input  logic       i_tx_lt_eop,
    input  logic       i_tx_lt_valid,
    output logic       o_tx_lt_ready,
    input  logic [7:0] i_tx_lt_data,
    output logic       o_tx_sop,
    output logic       o_tx_eop,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic [7:0] o_tx_data
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DATA   = 3'd1;
    localparam logic [2:0] S_PASS   = 3'd2;
    localparam logic [2:0] S_CRC_LO = 3'd3;
    localparam logic [2:0] S_CRC_HI = 3'd4;

    logic [2:0]  r_state;
    logic [15:0] r_crc;
    logic        r_valid;
    logic        r_sop;
    logic        r_eop;
    logic [7:0]  r_data;

    logic w_out_free;
    logic w_in_state;
    logic w_lt_ready;
    logic w_acc;
    logic w_oacc;
    logic w_is_data_pid;

    // Reflected CRC-16 (0xA001), LSB first, one whole byte per call.
    function automatic logic [15:0] f_crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    assign w_out_free    = ~r_valid | i_tx_ready;
    assign w_in_state    = (r_state == S_IDLE) | (r_state == S_DATA) | (r_state == S_PASS);
    assign w_lt_ready    = ~i_rst & i_tx_data_on & w_in_state & w_out_free;
    assign w_acc         = i_tx_lt_valid & w_lt_ready;
    assign w_oacc        = r_valid & i_tx_ready;
    assign w_is_data_pid = (i_tx_lt_data[1:0] == 2'b11);

    assign o_tx_lt_ready  = w_lt_ready;
    assign o_tx_sop_en    = w_acc & i_tx_lt_sop & (r_state == S_IDLE);
    assign o_tx_lt_eop_en = ~i_rst & w_oacc & r_eop;
    assign o_tx_valid     = r_valid;
    assign o_tx_sop       = r_sop;
    assign o_tx_eop       = r_eop;
    assign o_tx_data      = r_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_crc   <= 16'hFFFF;
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_data  <= 8'h00;
        end else if (!i_tx_data_on && (r_state != S_IDLE)) begin
            // Abort: drop whatever is in flight without ever showing an EOP.
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
        end else begin
            if (w_oacc) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_acc && i_tx_lt_sop) begin
                        r_valid <= 1'b1;
                        r_sop   <= 1'b1;
                        r_data  <= i_tx_lt_data;
                        if (w_is_data_pid) begin
                            r_crc   <= 16'hFFFF;
                            r_eop   <= 1'b0;
                            r_state <= i_tx_lt_eop ? S_CRC_LO : S_DATA;
                        end else begin
                            r_eop   <= i_tx_lt_eop;
                            r_state <= i_tx_lt_eop ? S_IDLE : S_PASS;
                        end
                    end
                end
                S_DATA: begin
                    if (w_acc) begin
                        r_valid <= 1'b1;
                        r_sop   <= 1'b0;
                        r_eop   <= 1'b0;
                        r_data  <= i_tx_lt_data;
                        r_crc   <= f_crc16_byte(r_crc, i_tx_lt_data);
                        if (i_tx_lt_eop) begin
                            r_state <= S_CRC_LO;
                        end
                    end
                end
                S_PASS: begin
                    if (w_acc) begin
                        r_valid <= 1'b1;
                        r_sop   <= 1'b0;
                        r_eop   <= i_tx_lt_eop;
                        r_data  <= i_tx_lt_data;
                        if (i_tx_lt_eop) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_CRC_LO: begin
                    if (w_out_free) begin
                        r_valid <= 1'b1;
                        r_sop   <= 1'b0;
                        r_eop   <= 1'b0;
                        r_data  <= ~r_crc[7:0];
                        r_state <= S_CRC_HI;
                    end
                end
                S_CRC_HI: begin
                    if (w_out_free) begin
                        r_valid <= 1'b1;
                        r_sop   <= 1'b0;
                        r_eop   <= 1'b1;
                        r_data  <= ~r_crc[15:8];
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc16_t.sv
// Bench for crc16_t: randomized packets and backpressure checked against a bit-serial CRC reference model.
module tb_crc16_t;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] dat;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst, data_on, lt_sop, lt_eop, lt_valid, tx_ready;
    logic [7:0] lt_data;
    logic       sop_en, lt_eop_en, lt_ready, tx_sop, tx_eop, tx_valid;
    logic [7:0] tx_data;

    int    tests = 0;
    int    fails = 0;
    beat_t got[$];
    beat_t exp[$];
    int    sop_en_cnt = 0;
    int    eop_en_cnt = 0;
    int    proto_err  = 0;
    logic  prev_stall = 1'b0;
    beat_t prev;

    always #5 clk = ~clk;

    crc16_t dut (
        .i_clk(clk), .i_rst(rst), .i_tx_data_on(data_on),
        .o_tx_sop_en(sop_en), .o_tx_lt_eop_en(lt_eop_en),
        .i_tx_lt_sop(lt_sop), .i_tx_lt_eop(lt_eop), .i_tx_lt_valid(lt_valid),
        .o_tx_lt_ready(lt_ready), .i_tx_lt_data(lt_data),
        .o_tx_sop(tx_sop), .o_tx_eop(tx_eop), .o_tx_valid(tx_valid),
        .i_tx_ready(tx_ready), .o_tx_data(tx_data)
    );

    // Monitor: records accepted output beats and protocol violations between edges.
    always @(negedge clk) begin
        if (sop_en) sop_en_cnt++;
        if (lt_eop_en) eop_en_cnt++;
        if (lt_eop_en !== (tx_valid & tx_ready & tx_eop)) proto_err++;
        if (tx_valid && !tx_ready && lt_ready) proto_err++;
        if (prev_stall && (tx_valid !== 1'b1 || {tx_sop, tx_eop, tx_data} !== prev)) proto_err++;
        if (tx_valid && tx_ready) got.push_back({tx_sop, tx_eop, tx_data});
        prev_stall = tx_valid && !tx_ready && !rst && data_on;
        prev       = {tx_sop, tx_eop, tx_data};
    end

    function automatic logic [15:0] model_crc(input bq_t payload);
        logic [15:0] r;
        logic        fb;
        r = 16'hFFFF;
        foreach (payload[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = r[0] ^ payload[i][k];
                r  = r >> 1;
                if (fb) r = r ^ 16'hA001;
            end
        end
        return ~r;
    endfunction

    function automatic void build_exp(input bq_t pkt);
        bq_t         pl;
        logic [15:0] c;
        logic [7:0]  pid;
        exp.delete();
        pid = pkt[0];
        if (pid[1:0] == 2'b11) begin
            for (int i = 1; i < pkt.size(); i++) pl.push_back(pkt[i]);
            exp.push_back({1'b1, 1'b0, pid});
            foreach (pl[i]) exp.push_back({1'b0, 1'b0, pl[i]});
            c = model_crc(pl);
            exp.push_back({1'b0, 1'b0, c[7:0]});
            exp.push_back({1'b0, 1'b1, c[15:8]});
        end else begin
            for (int i = 0; i < pkt.size(); i++)
                exp.push_back({(i == 0), (i == pkt.size() - 1), pkt[i]});
        end
    endfunction

    task automatic clear_mon();
        got.delete();
        sop_en_cnt = 0;
        eop_en_cnt = 0;
    endtask

    task automatic send_pkt(input bq_t pkt, input bit bp, input bit last_eop);
        int   i = 0;
        int   guard = 0;
        logic acc;
        while (i < pkt.size() && guard < 2000) begin
            lt_valid = 1'b1;
            lt_data  = pkt[i];
            lt_sop   = (i == 0);
            lt_eop   = last_eop && (i == pkt.size() - 1);
            tx_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            acc = lt_ready;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        lt_valid = 1'b0; lt_sop = 1'b0; lt_eop = 1'b0;
        tests++;
        if (i != pkt.size()) begin
            fails++;
            $display("FAIL send_timeout accepted %0d bytes, required %0d", i, pkt.size());
        end
    endtask

    task automatic drain(input bit bp);
        int guard = 0;
        while (tx_valid && guard < 500) begin
            tx_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(posedge clk); #1;
            guard++;
        end
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (tx_valid) begin
            fails++;
            $display("FAIL drain_timeout tx_valid still 1, required 0");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; data_on = 1'b1; lt_valid = 1'b1; lt_sop = 1'b1; lt_eop = 1'b0;
        lt_data = 8'hC3; tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({tx_valid, tx_sop, tx_eop, tx_data} !== 11'h000) begin
            fails++;
            $display("FAIL reset_outputs got v%b s%b e%b d%h, required all 0", tx_valid, tx_sop, tx_eop, tx_data);
        end
        tests++;
        if ({lt_ready, sop_en, lt_eop_en} !== 3'b000) begin
            fails++;
            $display("FAIL reset_ready_pulses got %b, required 000", {lt_ready, sop_en, lt_eop_en});
        end
        lt_valid = 1'b0; lt_sop = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (lt_ready !== 1'b1) begin
            fails++;
            $display("FAIL idle_ready got %b, required 1", lt_ready);
        end
        data_on = 1'b0; #1;
        tests++;
        if (lt_ready !== 1'b0) begin
            fails++;
            $display("FAIL idle_disabled_ready got %b, required 0", lt_ready);
        end
        data_on = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_check_string(input bit bp, input string nm);
        bq_t pkt;
        pkt.push_back(8'hC3);
        for (int i = 0; i < 9; i++) pkt.push_back(8'h31 + 8'(i));
        build_exp(pkt);
        clear_mon();
        proto_err = 0;
        send_pkt(pkt, bp, 1'b1);
        drain(bp);
        tests++;
        if (got.size() != exp.size()) begin
            fails++;
            $display("FAIL %s beat_count got %0d, required %0d", nm, got.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            tests++;
            if (got[i] !== exp[i]) begin
                fails++;
                $display("FAIL %s beat%0d got %h, required %h", nm, i, got[i], exp[i]);
            end
        end
        tests++;
        if (got.size() == 12 && (got[10].dat !== 8'hC8 || got[11].dat !== 8'hB4)) begin
            fails++;
            $display("FAIL %s crc_bytes got %h %h, required C8 B4", nm, got[10].dat, got[11].dat);
        end
        tests++;
        if (sop_en_cnt != 1 || eop_en_cnt != 1) begin
            fails++;
            $display("FAIL %s pulses got sop_en %0d eop_en %0d, required 1 1", nm, sop_en_cnt, eop_en_cnt);
        end
        tests++;
        if (proto_err != 0) begin
            fails++;
            $display("FAIL %s protocol got %0d violations, required 0", nm, proto_err);
        end
    endtask

    task automatic test_zero_len();
        bq_t pkt;
        pkt.push_back(8'h4B);
        clear_mon();
        send_pkt(pkt, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (lt_ready !== 1'b0) begin
                fails++;
                $display("FAIL zero_len_crc_ready beat%0d got %b, required 0", k, lt_ready);
            end
            @(posedge clk); #1;
        end
        drain(1'b0);
        exp.delete();
        exp.push_back({1'b1, 1'b0, 8'h4B});
        exp.push_back({1'b0, 1'b0, 8'h00});
        exp.push_back({1'b0, 1'b1, 8'h00});
        tests++;
        if (got.size() != 3) begin
            fails++;
            $display("FAIL zero_len beat_count got %0d, required 3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            tests++;
            if (got[i] !== exp[i]) begin
                fails++;
                $display("FAIL zero_len beat%0d got %h, required %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_ack();
        bq_t pkt;
        pkt.push_back(8'hD2);
        clear_mon();
        send_pkt(pkt, 1'b0, 1'b1);
        drain(1'b0);
        tests++;
        if (got.size() != 1 || got[0] !== {1'b1, 1'b1, 8'hD2}) begin
            fails++;
            $display("FAIL ack got %0d beats first %h, required 1 beat 3d2", got.size(), got.size() > 0 ? got[0] : 10'h0);
        end
        tests++;
        if (sop_en_cnt != 1 || eop_en_cnt != 1) begin
            fails++;
            $display("FAIL ack_pulses got sop_en %0d eop_en %0d, required 1 1", sop_en_cnt, eop_en_cnt);
        end
    endtask

    task automatic test_random();
        logic [7:0] data_pids[4] = '{8'hC3, 8'h4B, 8'h87, 8'h0F};
        logic [7:0] pass_pids[5] = '{8'hD2, 8'h5A, 8'hE1, 8'h69, 8'h2D};
        for (int n = 0; n < 12; n++) begin
            bq_t pkt;
            bit  bp;
            int  len;
            bp  = ($urandom_range(0, 1) == 1);
            len = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) pkt.push_back(data_pids[$urandom_range(0, 3)]);
            else pkt.push_back(pass_pids[$urandom_range(0, 4)]);
            for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
            build_exp(pkt);
            clear_mon();
            proto_err = 0;
            send_pkt(pkt, bp, 1'b1);
            drain(bp);
            tests++;
            if (got.size() != exp.size()) begin
                fails++;
                $display("FAIL random%0d beat_count got %0d, required %0d", n, got.size(), exp.size());
            end
            for (int i = 0; i < exp.size() && i < got.size(); i++) begin
                tests++;
                if (got[i] !== exp[i]) begin
                    fails++;
                    $display("FAIL random%0d beat%0d got %h, required %h", n, i, got[i], exp[i]);
                end
            end
            tests++;
            if (eop_en_cnt != 1 || proto_err != 0) begin
                fails++;
                $display("FAIL random%0d eop_en %0d proto %0d, required 1 0", n, eop_en_cnt, proto_err);
            end
        end
    endtask

    task automatic test_abort();
        bq_t pkt;
        bq_t z;
        pkt = '{8'hC3, 8'h31, 8'h32, 8'h33, 8'h34};
        z.push_back(8'h4B);
        clear_mon();
        send_pkt(pkt, 1'b0, 1'b0);
        data_on = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (tx_valid !== 1'b0 || tx_eop !== 1'b0) begin
            fails++;
            $display("FAIL abort_out got valid %b eop %b, required 0 0", tx_valid, tx_eop);
        end
        @(posedge clk); #1;
        tests++;
        if (eop_en_cnt != 0 || got.size() != 5 || got[got.size() - 1].eop !== 1'b0) begin
            fails++;
            $display("FAIL abort_eop got eop_en %0d beats %0d, required 0 5 no eop", eop_en_cnt, got.size());
        end
        data_on = 1'b1;
        clear_mon();
        send_pkt(z, 1'b0, 1'b1);
        drain(1'b0);
        build_exp(z);
        tests++;
        if (got.size() != 3 || got[1].dat !== exp[1].dat || got[2] !== exp[2]) begin
            fails++;
            $display("FAIL abort_reinit got %0d beats, required 4B 00 00", got.size());
        end
    endtask

    task automatic test_rst_mid();
        bq_t z;
        z.push_back(8'h4B);
        send_pkt(z, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({tx_valid, tx_sop, tx_eop, tx_data, sop_en, lt_eop_en, lt_ready} !== 14'h0) begin
            fails++;
            $display("FAIL rst_mid_outputs got v%b s%b e%b d%h, required all 0", tx_valid, tx_sop, tx_eop, tx_data);
        end
        rst = 1'b0;
        clear_mon();
        for (int i = 0; i < 5; i++) begin
            lt_valid = 1'b1; lt_sop = 1'b0; lt_eop = (i == 4); lt_data = 8'($urandom);
            tx_ready = 1'b1;
            @(posedge clk); #1;
        end
        lt_valid = 1'b0; lt_eop = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (got.size() != 0 || sop_en_cnt != 0 || tx_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_drop got %0d beats sop_en %0d, required 0 0", got.size(), sop_en_cnt);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_check_string(1'b0, "check_string");
        test_zero_len();
        test_ack();
        test_check_string(1'b1, "backpressure");
        test_abort();
        test_random();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
